// File: rtl/wt4_share_arb.sv
// Shares one 4-operand, 4-bit carry-save reduction tree between N_REQ requesters.
// Round-robin grant, a 3:2 compression stage and a final carry-propagate add stage.
module wt4_share_arb #(
   parameter int N_REQ      = 3,
   parameter bit SIGNED_OPS = 1'b1
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic [N_REQ-1:0]    REQ,
   input  logic [16*N_REQ-1:0] OPS,
   output logic [N_REQ-1:0]    GNT,
   output logic                RESULT_VALID,
   output logic [5:0]          RESULT,
   output logic [1:0]          RESULT_ID,
   input  logic                RESULT_READY
);

   // Result handshake: a transfer happens on a rising edge where RESULT_VALID and
   // RESULT_READY are both high; while VALID is high and READY low, RESULT and
   // RESULT_ID hold and the pipeline behind them stalls.

   logic [1:0]  ptr;
   logic        s1_valid;
   logic [5:0]  s1_sum;
   logic [5:0]  s1_carry;
   logic [5:0]  s1_op3;
   logic [1:0]  s1_id;

   logic        adv1;
   logic        adv2;
   logic        gnt_any;
   logic        grant;
   logic [1:0]  gnt_idx;
   logic [2:0]  cand;
   logic [15:0] sel_ops;
   logic [5:0]  e0, e1, e2, e3;

   function automatic logic [5:0] ext4(input logic [3:0] v);
      return SIGNED_OPS ? {{2{v[3]}}, v} : {2'b00, v};
   endfunction

   always_comb begin
      adv2    = !RESULT_VALID || RESULT_READY;
      adv1    = !s1_valid || adv2;
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      // Search upward from the pointer, wrapping at N_REQ.
      for (int k = 0; k < N_REQ; k++) begin
         cand = 3'(ptr) + 3'(k);
         if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
         if (!gnt_any && REQ[cand[1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[1:0];
         end
      end
      grant = RESET_N && adv1 && gnt_any;
      GNT   = '0;
      if (grant) GNT[gnt_idx] = 1'b1;
      sel_ops = OPS[{gnt_idx, 4'b0000} +: 16];
      e0 = ext4(sel_ops[3:0]);
      e1 = ext4(sel_ops[7:4]);
      e2 = ext4(sel_ops[11:8]);
      e3 = ext4(sel_ops[15:12]);
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         ptr      <= '0;
         s1_valid <= 1'b0;
         s1_sum   <= '0;
         s1_carry <= '0;
         s1_op3   <= '0;
         s1_id    <= '0;
      end else begin
         if (adv1) begin
            s1_valid <= grant;
            s1_sum   <= e0 ^ e1 ^ e2;
            s1_carry <= ((e0 & e1) | (e0 & e2) | (e1 & e2)) << 1;
            s1_op3   <= e3;
            s1_id    <= gnt_idx;
         end
         if (grant) ptr <= (gnt_idx == 2'(N_REQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
      end
   end

   // Sign/zero extension to 6 bits makes the modulo-64 sum exact; no overflow.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         RESULT_VALID <= 1'b0;
         RESULT       <= '0;
         RESULT_ID    <= '0;
      end else if (adv2) begin
         RESULT_VALID <= s1_valid;
         RESULT       <= s1_sum + s1_carry + s1_op3;
         RESULT_ID    <= s1_id;
      end
   end

endmodule

// File: tb/tb_wt4_share_arb.sv
// Directed and randomized checks of wt4_share_arb in both signed and unsigned modes.
module tb_wt4_share_arb;
   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [16*N-1:0] ops;
   logic          ready;
   logic [N-1:0]  gnt_s, gnt_u;
   logic          rv_s, rv_u;
   logic [5:0]    res_s, res_u;
   logic [1:0]    id_s, id_u;

   int vectors = 0;
   int miscompares = 0;
   logic [13:0] exp_q[$];   // {id, signed result, unsigned result}

   always #5 clk = ~clk;

   wt4_share_arb #(.N_REQ(N), .SIGNED_OPS(1'b1)) u_dut_s (
      .CLK(clk), .RESET_N(rst_n), .REQ(req), .OPS(ops), .GNT(gnt_s),
      .RESULT_VALID(rv_s), .RESULT(res_s), .RESULT_ID(id_s), .RESULT_READY(ready));

   wt4_share_arb #(.N_REQ(N), .SIGNED_OPS(1'b0)) u_dut_u (
      .CLK(clk), .RESET_N(rst_n), .REQ(req), .OPS(ops), .GNT(gnt_u),
      .RESULT_VALID(rv_u), .RESULT(res_u), .RESULT_ID(id_u), .RESULT_READY(ready));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      ready = 1'b1;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 3'b111;
      ops   = {16'h2222, 16'h1111, 16'h0000};
      ready = 1'b1;
      step();
      @(negedge clk);
      vectors++; if (gnt_s !== 3'b000) begin miscompares++; $display("FAIL reset_gnt: got %b want 000", gnt_s); end
      vectors++; if (rv_s !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", rv_s); end
      vectors++; if (res_s !== 6'h00) begin miscompares++; $display("FAIL reset_result: got %h want 00", res_s); end
      vectors++; if (id_s !== 2'd0) begin miscompares++; $display("FAIL reset_id: got %0d want 0", id_s); end
      vectors++; if (rv_u !== 1'b0) begin miscompares++; $display("FAIL reset_valid_u: got %b want 0", rv_u); end
      step();
      rst_n = 1'b1;
      req   = '0;
   endtask

   task automatic test_single();
      req   = 3'b001;
      ops   = {32'h0, 16'h7777};
      ready = 1'b1;
      @(negedge clk);
      vectors++; if (gnt_s !== 3'b001) begin miscompares++; $display("FAIL single_gnt: got %b want 001", gnt_s); end
      step();
      req = '0;
      @(negedge clk);
      vectors++; if (rv_s !== 1'b0) begin miscompares++; $display("FAIL single_early: got %b want 0", rv_s); end
      step();
      @(negedge clk);
      vectors++; if (rv_s !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", rv_s); end
      vectors++; if (res_s !== 6'h1C) begin miscompares++; $display("FAIL single_result: got %h want 1c", res_s); end
      vectors++; if (id_s !== 2'd0) begin miscompares++; $display("FAIL single_id: got %0d want 0", id_s); end
      step();
   endtask

   task automatic test_extend();
      logic [15:0] t_ops [4];
      logic [5:0]  t_s [4];
      logic [5:0]  t_u [4];
      t_ops = '{16'h0008, 16'h8888, 16'hFFFF, 16'h000F};
      t_s   = '{6'h38, 6'h20, 6'h3C, 6'h3F};
      t_u   = '{6'h08, 6'h20, 6'h3C, 6'h0F};
      ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         req = 3'b001;
         ops = {32'h0, t_ops[t]};
         @(negedge clk);
         vectors++; if (gnt_s !== 3'b001) begin miscompares++; $display("FAIL ext_gnt[%0d]: got %b want 001", t, gnt_s); end
         step();
         req = '0;
         step();
         @(negedge clk);
         vectors++; if (rv_s !== 1'b1 || res_s !== t_s[t]) begin miscompares++; $display("FAIL ext_signed[%0d]: got v=%b %h want v=1 %h", t, rv_s, res_s, t_s[t]); end
         vectors++; if (rv_u !== 1'b1 || res_u !== t_u[t]) begin miscompares++; $display("FAIL ext_unsigned[%0d]: got v=%b %h want v=1 %h", t, rv_u, res_u, t_u[t]); end
         step();
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_g;
      int k;
      do_reset();
      req   = 3'b111;
      ops   = {16'h2222, 16'h1111, 16'h0000};
      ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_g = 3'b001 << (c % 3);
         vectors++; if (gnt_s !== exp_g) begin miscompares++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt_s, exp_g); end
         if (c >= 2) begin
            k = (c - 2) % 3;
            vectors++; if (rv_s !== 1'b1 || res_s !== 6'(4 * k) || id_s !== 2'(k)) begin
               miscompares++; $display("FAIL rr_result[%0d]: got v=%b %h id=%0d want v=1 %h id=%0d", c, rv_s, res_s, id_s, 6'(4 * k), k);
            end
         end
         step();
      end
      req = '0;
      step();
      step();
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] exp_g [9];
      logic         exp_v [9];
      logic [5:0]   exp_r [9];
      logic [1:0]   exp_i [9];
      exp_g = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
      exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_r = '{6'h00, 6'h00, 6'h04, 6'h04, 6'h04, 6'h04, 6'h0C, 6'h04, 6'h00};
      exp_i = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
      do_reset();
      ops   = {16'h0000, 16'h3333, 16'h1111};
      req   = 3'b011;
      ready = 1'b0;
      for (int c = 0; c < 9; c++) begin
         if (c == 1) req = 3'b010;
         if (c == 2) req = 3'b001;
         if (c == 5) ready = 1'b1;
         if (c == 6) req = 3'b000;
         @(negedge clk);
         vectors++; if (gnt_s !== exp_g[c]) begin miscompares++; $display("FAIL bp_gnt[%0d]: got %b want %b", c, gnt_s, exp_g[c]); end
         vectors++; if (rv_s !== exp_v[c]) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want %b", c, rv_s, exp_v[c]); end
         if (exp_v[c]) begin
            vectors++; if (res_s !== exp_r[c] || id_s !== exp_i[c]) begin
               miscompares++; $display("FAIL bp_result[%0d]: got %h id=%0d want %h id=%0d", c, res_s, id_s, exp_r[c], exp_i[c]);
            end
         end
         step();
      end
   endtask

   task automatic test_reset_flush();
      do_reset();
      ops   = {16'h5555, 16'h3333, 16'h1111};
      req   = 3'b011;
      ready = 1'b0;
      @(negedge clk);
      vectors++; if (gnt_s !== 3'b001) begin miscompares++; $display("FAIL flush_gnt0: got %b want 001", gnt_s); end
      step();
      req = 3'b010;
      @(negedge clk);
      vectors++; if (gnt_s !== 3'b010) begin miscompares++; $display("FAIL flush_gnt1: got %b want 010", gnt_s); end
      step();
      req = 3'b000;
      @(negedge clk);
      vectors++; if (rv_s !== 1'b1) begin miscompares++; $display("FAIL flush_buffered: got %b want 1", rv_s); end
      step();
      rst_n = 1'b0;
      req   = 3'b100;
      @(negedge clk);
      vectors++; if (gnt_s !== 3'b000) begin miscompares++; $display("FAIL flush_gnt_in_reset: got %b want 000", gnt_s); end
      step();
      rst_n = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      vectors++; if (rv_s !== 1'b0 || res_s !== 6'h00 || id_s !== 2'd0) begin
         miscompares++; $display("FAIL flush_cleared: got v=%b %h id=%0d want v=0 00 id=0", rv_s, res_s, id_s);
      end
      vectors++; if (gnt_s !== 3'b100) begin miscompares++; $display("FAIL flush_regrant: got %b want 100", gnt_s); end
      step();
      req = 3'b000;
      @(negedge clk);
      vectors++; if (rv_s !== 1'b0) begin miscompares++; $display("FAIL flush_no_stale: got %b want 0", rv_s); end
      step();
      @(negedge clk);
      vectors++; if (rv_s !== 1'b1 || res_s !== 6'h14 || id_s !== 2'd2) begin
         miscompares++; $display("FAIL flush_result: got v=%b %h id=%0d want v=1 14 id=2", rv_s, res_s, id_s);
      end
      step();
   endtask

   task automatic test_random();
      logic         pending [N];
      logic [15:0]  rops [N];
      int           waitc [N];
      int           mptr, w, ss, uu, idx;
      logic [3:0]   o;
      logic [N-1:0] exp_g;
      logic         s1_full, exp_any, prev_hold;
      logic [5:0]   prev_res;
      logic [1:0]   prev_id;
      logic [13:0]  e;
      do_reset();
      exp_q.delete();
      mptr = 0;
      prev_hold = 1'b0;
      prev_res = '0;
      prev_id = '0;
      for (int i = 0; i < N; i++) begin pending[i] = 1'b0; rops[i] = '0; waitc[i] = 0; end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
               if ($urandom_range(0, 15) == 0) begin pending[i] = 1'b0; waitc[i] = 0; end
            end else if ($urandom_range(0, 1) == 1) begin
               pending[i] = 1'b1;
               rops[i]    = 16'($urandom);
               waitc[i]   = 0;
            end
            req[i] = pending[i];
            ops[16*i +: 16] = pending[i] ? rops[i] : 16'($urandom);
         end
         ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         s1_full = exp_q.size() > (rv_s ? 1 : 0);
         exp_any = (|req) && (!s1_full || !rv_s || ready);
         vectors++; if ((gnt_s != '0) !== exp_any) begin miscompares++; $display("FAIL rand_gnt_any[%0d]: got %b want any=%b", cyc, gnt_s, exp_any); end
         vectors++; if (gnt_u !== gnt_s || rv_u !== rv_s) begin miscompares++; $display("FAIL rand_modes_agree[%0d]: got %b/%b want %b/%b", cyc, gnt_u, rv_u, gnt_s, rv_s); end
         if (prev_hold) begin
            vectors++; if (rv_s !== 1'b1 || res_s !== prev_res || id_s !== prev_id) begin
               miscompares++; $display("FAIL rand_hold[%0d]: got v=%b %h id=%0d want v=1 %h id=%0d", cyc, rv_s, res_s, id_s, prev_res, prev_id);
            end
         end
         prev_hold = rv_s && !ready;
         prev_res  = res_s;
         prev_id   = id_s;
         if (rv_s && ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++; $display("FAIL rand_spurious[%0d]: got result %h id=%0d want none", cyc, res_s, id_s);
            end else begin
               e = exp_q.pop_front();
               if (id_s !== e[13:12] || res_s !== e[11:6] || res_u !== e[5:0] || id_u !== e[13:12]) begin
                  miscompares++; $display("FAIL rand_result[%0d]: got id=%0d %h/%h want id=%0d %h/%h", cyc, id_s, res_s, res_u, e[13:12], e[11:6], e[5:0]);
               end
            end
         end
         if (gnt_s != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
               idx = (mptr + k) % N;
               if (w < 0 && req[idx]) w = idx;
            end
            if (w < 0) w = 0;
            exp_g = '0;
            exp_g[w] = 1'b1;
            vectors++; if (gnt_s !== exp_g) begin miscompares++; $display("FAIL rand_gnt_sel[%0d]: got %b want %b", cyc, gnt_s, exp_g); end
            ss = 0;
            uu = 0;
            for (int k = 0; k < 4; k++) begin
               o  = rops[w][4*k +: 4];
               ss += int'($signed(o));
               uu += int'(o);
            end
            exp_q.push_back({2'(w), 6'(ss), 6'(uu)});
            mptr = (w + 1) % N;
            pending[w] = 1'b0;
            waitc[w] = 0;
            for (int i = 0; i < N; i++) begin
               if (req[i] && i != w) begin
                  waitc[i]++;
                  vectors++; if (waitc[i] > N - 1) begin miscompares++; $display("FAIL rand_fair[%0d]: req %0d lost %0d times want <= %0d", cyc, i, waitc[i], N - 1); end
               end
            end
         end
         vectors++; if (exp_q.size() > 2) begin miscompares++; $display("FAIL rand_inflight[%0d]: got %0d want <= 2", cyc, exp_q.size()); end
         step();
      end
      req   = '0;
      ready = 1'b1;
      for (int d = 0; d < 4; d++) begin
         @(negedge clk);
         if (rv_s) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++; $display("FAIL rand_drain_spurious: got result %h want none", res_s);
            end else begin
               e = exp_q.pop_front();
               if (id_s !== e[13:12] || res_s !== e[11:6] || res_u !== e[5:0]) begin
                  miscompares++; $display("FAIL rand_drain_result: got id=%0d %h/%h want id=%0d %h/%h", id_s, res_s, res_u, e[13:12], e[11:6], e[5:0]);
               end
            end
         end
         step();
      end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_lost: got %0d outstanding want 0", exp_q.size()); end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      ops   = '0;
      ready = 1'b1;
      test_reset();
      test_single();
      test_extend();
      test_round_robin();
      test_back_to_back();
      test_reset_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
